// File: rtl/serial_paralelo_sync.sv
// -----------------------------------------------------------------------------
// serial_paralelo_sync
//
// Serial-to-parallel converter with comma-based byte alignment. One serial bit
// is sampled per rising edge of clk_32f, MSB of each byte first. The receiver
// hunts for the COM character at any bit offset. Once four COMs have been seen
// on consecutive byte boundaries, the byte alignment is locked for good (until
// reset). From then on, every byte boundary produces a one-cycle strobe. Data
// bytes are presented on data_out with valid_out high. COM and IDL are
// filtered: they drop valid_out and leave data_out holding the last data byte.
//
// Ports
//   clk_32f     in   1  bit clock, the only clock of the block
//   reset       in   1  synchronous, active-high reset
//   data_in     in   1  serial bit stream, MSB first
//   data_out    out  8  last recovered data byte (registered)
//   valid_out   out  1  data_out holds a data byte from the latest boundary
//   byte_strobe out  1  one-cycle pulse per byte boundary once locked
//   active      out  1  byte alignment locked, sticky until reset
//
// Parameters
//   COM  sync character (default 8'hBC)
//   IDL  idle character (default 8'h7C)
// -----------------------------------------------------------------------------
module serial_paralelo_sync #(
  parameter logic [7:0] COM = 8'hBC,
  parameter logic [7:0] IDL = 8'h7C
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Number of COMs on consecutive boundaries needed to declare lock.
  localparam logic [2:0] COM_LOCK = 3'd4;

  state_t     state_reg, state_next;
  logic [7:0] shreg_reg;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0] com_count_reg, com_count_next;
  logic [7:0] data_out_reg, data_out_next;
  logic       valid_reg, valid_next;
  logic       strobe_reg, strobe_next;
  logic       active_reg, active_next;

  // Candidate byte: the seven most recent bits plus the bit being sampled now.
  // Decisions are taken on the same edge that samples the eighth bit, so the
  // registered outputs appear one cycle after that bit was presented.
  logic [7:0] cand_byte;
  logic       is_com;
  logic       is_idl;
  logic       boundary;

  assign cand_byte = {shreg_reg[6:0], data_in};
  assign is_com    = (cand_byte == COM);
  assign is_idl    = (cand_byte == IDL);
  // The bit counter is zeroed on the edge that recognised a COM. It then reads
  // 0..7 while the next eight bits are sampled, so the 7 slot is the boundary.
  assign boundary  = (bit_cnt_reg == 3'd7);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_reg     <= SEARCH;
      shreg_reg     <= 8'h00;
      bit_cnt_reg   <= 3'd0;
      com_count_reg <= 3'd0;
      data_out_reg  <= 8'h00;
      valid_reg     <= 1'b0;
      strobe_reg    <= 1'b0;
      active_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= cand_byte;
      bit_cnt_reg   <= bit_cnt_next;
      com_count_reg <= com_count_next;
      data_out_reg  <= data_out_next;
      valid_reg     <= valid_next;
      strobe_reg    <= strobe_next;
      active_reg    <= active_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg + 3'd1;  // wraps 7 -> 0 naturally
    com_count_next = com_count_reg;
    data_out_next  = data_out_reg;
    valid_next     = valid_reg;
    strobe_next    = 1'b0;
    active_next    = active_reg;

    case (state_reg)
      SEARCH: begin
        // No alignment yet, so the counter is meaningless; keep it parked.
        bit_cnt_next = 3'd0;
        if (is_com) begin
          com_count_next = 3'd1;
          state_next     = ALIGN;
        end
      end

      ALIGN: begin
        if (boundary) begin
          if (is_com) begin
            if (com_count_reg >= COM_LOCK - 3'd1) begin
              com_count_next = COM_LOCK;
              state_next     = ACTIVE;
              active_next    = 1'b1;
            end else begin
              com_count_next = com_count_reg + 3'd1;
            end
          end else begin
            // Any non-COM at a boundary (IDL included) breaks the run.
            com_count_next = 3'd0;
            state_next     = SEARCH;
          end
        end
      end

      ACTIVE: begin
        // Alignment is never revisited here; the counter just keeps wrapping.
        if (boundary) begin
          strobe_next = 1'b1;
          if (is_com || is_idl) begin
            valid_next = 1'b0;
          end else begin
            data_out_next = cand_byte;
            valid_next    = 1'b1;
          end
        end
      end

      default: begin
        // Unused encoding: recover by hunting again.
        state_next     = SEARCH;
        bit_cnt_next   = 3'd0;
        com_count_next = 3'd0;
      end
    endcase
  end

  assign data_out    = data_out_reg;
  assign valid_out   = valid_reg;
  assign byte_strobe = strobe_reg;
  assign active      = active_reg;

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo_sync
//
// The stimulus process shifts directed bytes into the DUT, one bit per clock
// and MSB first. Right after the edge that completes a byte it expects to see
// reported, it pushes the expected {data_out, valid_out} into a queue. A
// separate monitor runs on the falling edge. Whenever byte_strobe is high, it
// pops the queue and compares. A queued entry with no strobe, or a strobe with
// an empty queue, is an error. Between strobes, the monitor also checks that
// data_out and valid_out hold their values and that active never drops without
// a reset.
// -----------------------------------------------------------------------------
module tb_serial_paralelo_sync;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  serial_paralelo_sync dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks   = 0;
  int         n_fail     = 0;
  logic       rst_q      = 1'b1;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_valid = 1'b0;
  logic       prev_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(posedge clk_32f) rst_q <= reset;

  always @(negedge clk_32f) begin
    if (byte_strobe) begin
      check("strobe_only_when_active", active, 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: data_out=%02h valid_out=%0b, no byte expected",
                 data_out, valid_out);
      end else begin
        mon_e = exp_q.pop_front();
        $display("byte boundary: data_out=%02h valid_out=%0b (expected %02h/%0b)",
                 data_out, valid_out, mon_e.data, mon_e.valid);
        check("byte_data", data_out, mon_e.data);
        check("byte_valid", valid_out, mon_e.valid);
      end
    end else begin
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_strobe: byte_strobe=0, required 1 (expected data %02h)", mon_e.data);
      end
      if (!rst_q) begin
        check("data_hold_between_boundaries", data_out, prev_data);
        check("valid_hold_between_boundaries", valid_out, prev_valid);
      end
    end
    if (!rst_q && prev_active) check("active_sticky", active, 1);
    prev_data   = data_out;
    prev_valid  = valid_out;
    prev_active = active;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_out,
                           input logic [7:0] exp_d, input logic exp_v);
    exp_t e;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    if (expect_out) begin
      e.data  = exp_d;
      e.valid = exp_v;
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      send_bit(i[0]);
      check("reset_data_out", data_out, 8'h00);
      check("reset_valid_out", valid_out, 0);
      check("reset_byte_strobe", byte_strobe, 0);
      check("reset_active", active, 0);
    end
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] com_b;
    com_b = 8'hBC;

    // Reset held three cycles with toggling data.
    apply_reset(3);

    // Lock at offset 0: active rises on the edge of bit 32, then FF is reported.
    for (int k = 0; k < 3; k++) send_byte(8'hBC, 0, 8'h00, 0);
    for (int i = 7; i >= 1; i--) send_bit(com_b[i]);
    check("active_before_bit32", active, 0);
    send_bit(com_b[0]);
    check("active_after_bit32", active, 1);
    check("valid_at_lock", valid_out, 0);
    send_byte(8'hFF, 1, 8'hFF, 1);
    check("data_after_ff", data_out, 8'hFF);

    // IDL then COM while active: strobes, valid drops, data holds FF.
    send_byte(8'h7C, 1, 8'hFF, 0);
    send_byte(8'hBC, 1, 8'hFF, 0);
    check("data_hold_after_idl_com", data_out, 8'hFF);
    check("valid_after_idl_com", valid_out, 0);
    send_byte(8'hA5, 1, 8'hA5, 1);

    // Reset at bit 3 of a byte discards everything; re-lock needs four COMs.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset = 1'b1;
    send_bit(1'b1);
    check("midbyte_reset_active", active, 0);
    check("midbyte_reset_data", data_out, 8'h00);
    check("midbyte_reset_valid", valid_out, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) send_byte(8'hBC, 0, 8'h00, 0);
    check("three_coms_not_locked", active, 0);
    send_byte(8'hBC, 0, 8'h00, 0);
    check("relock_after_reset", active, 1);
    send_byte(8'h33, 1, 8'h33, 1);

    // Lock at offset 3.
    apply_reset(3);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 0; k < 4; k++) send_byte(8'hBC, 0, 8'h00, 0);
    check("offset3_locked", active, 1);
    send_byte(8'h15, 1, 8'h15, 1);
    send_byte(8'h3C, 1, 8'h3C, 1);

    // IDL breaks the COM run: three COMs, IDL, then a fresh four.
    apply_reset(3);
    for (int k = 0; k < 3; k++) send_byte(8'hBC, 0, 8'h00, 0);
    send_byte(8'h7C, 0, 8'h00, 0);
    check("no_lock_through_idl", active, 0);
    for (int k = 0; k < 3; k++) send_byte(8'hBC, 0, 8'h00, 0);
    check("no_lock_after_three_fresh", active, 0);
    send_byte(8'hBC, 0, 8'h00, 0);
    check("lock_after_four_fresh", active, 1);
    send_byte(8'h20, 1, 8'h20, 1);

    // Let the monitor settle the last strobe.
    send_bit(1'b0);
    send_bit(1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
